// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: opcodes and sequencer state encoding shared by the arith sequencer files
package arith_seq_pkg;

   localparam logic [1:0] ARITH_ADD = 2'b00;
   localparam logic [1:0] ARITH_SUB = 2'b01;
   localparam logic [1:0] ARITH_MUL = 2'b10;
   localparam logic [1:0] ARITH_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seqState_e;

endpackage

// File: rtl/arith_seq_arith.sv
// arith: combinational 32-bit add/sub/mul/div datapath
module arith
   import arith_seq_pkg::*;
(
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        S_or_U,
   input  logic [1:0]  opSel,
   output logic [31:0] ArithAnswer
);

   logic [31:0] absA;
   logic [31:0] absB;
   logic [31:0] uQuot;
   logic [31:0] quot;
   logic        negQ;

   // Signed divide runs on magnitudes with a sign fix-up; divide by zero yields all ones
   always_comb begin
      absA = (S_or_U && opA[31]) ? -opA : opA;
      absB = (S_or_U && opB[31]) ? -opB : opB;
      uQuot = (absB == 32'd0) ? '1 : absA / absB;
      negQ = S_or_U && (opA[31] ^ opB[31]) && (opB != 32'd0);
      quot = negQ ? -uQuot : uQuot;
      ArithAnswer = (opSel == ARITH_ADD) ? opA + opB :
                    (opSel == ARITH_SUB) ? opA - opB :
                    (opSel == ARITH_MUL) ? opA * opB : quot;
   end

endmodule

// File: rtl/arith_seq.sv
// arith_seq: valid/ready sequencer holding operands on the arith unit for SETTLE_CYCLES
module arith_seq
   import arith_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int TAG_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_signed,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [15:0]      op_count
);

   seqState_e        state;
   seqState_e        stateNext;
   logic [3:0]       settleCnt;
   logic [31:0]      regA;
   logic [31:0]      regB;
   logic             regSigned;
   logic [1:0]       regOp;
   logic [TAG_W-1:0] regTag;
   logic [31:0]      arithAnswer;
   logic             accept;
   logic             rspHs;
   logic             settleDone;

   arith uArith (
      .opA        (regA),
      .opB        (regB),
      .S_or_U     (regSigned),
      .opSel      (regOp),
      .ArithAnswer(arithAnswer)
   );

   // Handshake decode; req_ready never looks at req_valid
   always_comb begin
      req_ready = (state == IDLE) || (state == RESP && rsp_ready);
      accept = req_valid && req_ready;
      rspHs = rsp_valid && rsp_ready;
      settleDone = (state == SETTLE) && (settleCnt == 4'd0);
   end

   // Next-state: a simultaneous handshake and accept in RESP goes straight back to SETTLE
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    stateNext = accept ? SETTLE : IDLE;
         SETTLE:  stateNext = settleDone ? RESP : SETTLE;
         RESP:    stateNext = accept ? SETTLE : rsp_ready ? IDLE : RESP;
         default: stateNext = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= stateNext;
   end

   // Operand capture, settle countdown, result capture and response counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         settleCnt <= '0;
         regA <= '0;
         regB <= '0;
         regSigned <= 1'b0;
         regOp <= '0;
         regTag <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_tag <= '0;
         op_count <= '0;
      end else begin
         if (accept) begin
            regA <= req_a;
            regB <= req_b;
            regSigned <= req_signed;
            regOp <= req_op;
            regTag <= req_tag;
            settleCnt <= 4'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE && settleCnt != 4'd0) begin
            settleCnt <= settleCnt - 4'd1;
         end
         if (settleDone) begin
            rsp_data <= arithAnswer;
            rsp_tag <= regTag;
            rsp_valid <= 1'b1;
         end else if (rspHs) begin
            rsp_valid <= 1'b0;
         end
         if (rspHs) op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: doc/arith_seq.md
ARITH_SEQ -- requirements
Module: arith_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of clk cycles operands are held on the arith unit before the result is captured (legal range 1..15).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the request/response tag.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 The block SHALL have ports req_a, req_b  input  32 each  operands.
REQ-008 The block SHALL have port req_signed  input  1  signed/unsigned select, driven to the arith unit S_or_U.
REQ-009 The block SHALL have port req_op  input  2  arith opcode.
REQ-010 The block SHALL have port req_tag  input  TAG_W  caller tag, returned with the result.
REQ-011 The block SHALL have port rsp_valid  output  1  result present.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer takes result when high with rsp_valid.
REQ-013 The block SHALL have ports rsp_data  output  32  result; rsp_tag  output  TAG_W  tag of that result.
REQ-014 The block SHALL have port op_count  output  16  completed-response counter.

Function
REQ-015 State machine SHALL have states IDLE, SETTLE, RESP.
REQ-016 req_ready SHALL equal (state==IDLE) or (state==RESP and rsp_ready); combinational from state and rsp_ready only, never from req_valid.
REQ-017 On accept (req_valid and req_ready), operands, req_signed, req_op and req_tag SHALL be registered; state goes to SETTLE and the settle counter loads SETTLE_CYCLES-1.
REQ-018 Registered operands SHALL drive the internal arith instance continuously; they SHALL NOT change outside an accept.
REQ-019 In SETTLE, counter decrements each cycle; when counter is 0, ArithAnswer SHALL be captured into rsp_data, tag into rsp_tag, rsp_valid set, state to RESP.
REQ-020 Latency: accept at edge k SHALL yield rsp_valid high starting at edge k+SETTLE_CYCLES (default: next cycle).
REQ-021 In RESP, rsp_data, rsp_tag, rsp_valid SHALL hold stable until rsp_ready is high.
REQ-022 Response handshake with no simultaneous accept: rsp_valid clears, state to IDLE.
REQ-023 Simultaneous response handshake and new accept in RESP: new request SHALL be registered and state goes to SETTLE; rsp_valid clears that edge (no bubble on request side).
REQ-024 op_count SHALL increment by 1 on each response handshake and wrap 16'hFFFF to 0.
REQ-025 rsp_data SHALL equal the arith unit output bit-for-bit; no extension, saturation or flags.
REQ-026 req_valid while in SETTLE SHALL be ignored (req_ready low); caller holds the request.

Reset
REQ-027 When rst_n is low at a clk edge: state IDLE, rsp_valid 0, rsp_data 0, rsp_tag 0, op_count 0, settle counter 0, operand registers 0.
REQ-028 Reset during SETTLE or RESP SHALL discard the in-flight operation with no response emitted.
REQ-029 req_ready SHALL be 1 the first cycle after reset is released.

Structure
REQ-030 Opcode constants ARITH_ADD=2'b00, ARITH_SUB=2'b01, ARITH_MUL=2'b10, ARITH_DIV=2'b11 and the state encoding SHALL live in the shared ALU package.
REQ-031 The block SHALL instantiate exactly one sub-module, arith, as the compute datapath.

Verification
REQ-032 Reset then accept add 5+7, tag 3, rsp_ready high -> rsp_valid next cycle, rsp_data 12, rsp_tag 3, op_count 1.
REQ-033 Sub 3-5 with rsp_ready low 4 cycles -> rsp_data 32'hFFFFFFFE and rsp_tag held stable all 4 cycles; req_ready low until rsp_ready high.
REQ-034 Back-to-back 8 requests, req_valid and rsp_ready always high, SETTLE_CYCLES=1 -> one response every 2 cycles, tags in order, op_count 8.
REQ-035 SETTLE_CYCLES=4, accept at edge k -> rsp_valid first high at edge k+4, req_ready low edges k+1..k+3.
REQ-036 Reset asserted mid-SETTLE -> no rsp_valid afterwards, all outputs zero, req_ready 1 after release.
REQ-037 Preload op_count to 16'hFFFF via 65535 responses -> next handshake yields op_count 0.
